// File: rtl/instr_mem_ldr.sv
// ---------------------------------------------------------------------------
// instr_mem_ldr
//   Run-time loadable instruction memory for the 16-bit single-cycle MIPS core.
//   Fetch is combinational. A byte-serial valid/ready port, driven by a small
//   FSM, writes program words into the array. The core is stalled while a
//   load is in progress.
//
//   Optional build macro: IMEM_ALIGN_CHECK_EN
//     When defined, a misaligned pc in RUN gives a NOP and raises fetch_fault.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     pc           byte address of the fetch
//     instruction  fetched word, combinational (NOP while stalled or faulted)
//     fetch_fault  fetch outside the array (or misaligned, with the macro)
//     cpu_stall    high while the loader owns the memory (registered)
//     ld_start     one-cycle pulse that begins a load
//     ld_valid     load byte valid
//     ld_byte      load data, MSB-first within each word
//     ld_last      final byte of the program
//     ld_ready     byte accepted when ld_valid && ld_ready
//     load_count   words written by the last or current load
//
//   state | meaning
//   RUN   | core fetches from the array; loader idle
//   LOAD  | core stalled; bytes assembled and written into the array
// ---------------------------------------------------------------------------
module instr_mem_ldr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_fault,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   load_count
);

    localparam int BPW   = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int OFS_W = $clog2(BPW);
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;

    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   assembled;
    logic [PC_W-1:0]     word_addr;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            load_count_q <= load_count_d;
        end
    end

    // Array is deliberately outside the reset domain: a reset mid-load keeps
    // every word already written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    // Bytes enter at the bottom and move up, so the first byte ends up MSB.
    assign assembled = (asm_q << 8) | DATA_W'(ld_byte);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        load_count_d = load_count_q;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            RUN: begin
                if (ld_start) begin
                    state_d      = LOAD;
                    wr_ptr_d     = '0;
                    byte_cnt_d   = '0;
                    asm_d        = '0;
                    load_count_d = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    if ((byte_cnt_q == BC_W'(BPW - 1)) || ld_last) begin
                        // A short final word is left-justified: the missing
                        // low bytes are shifted in as zeros.
                        mem_we       = 1'b1;
                        mem_wdata    = assembled << (8 * (BPW - 1 - int'(byte_cnt_q)));
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        load_count_d = load_count_q + 1'b1;
                        byte_cnt_d   = '0;
                        asm_d        = '0;
                        if (ld_last || (wr_ptr_q == ADDR_W'(DEPTH - 1))) begin
                            state_d = RUN;
                        end
                    end else begin
                        asm_d      = assembled;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign cpu_stall  = (state_q == LOAD);
    assign ld_ready   = (state_q == LOAD);
    assign load_count = load_count_q;

    assign word_addr = pc >> OFS_W;

    always_comb begin
        instruction = '0;
        fetch_fault = 1'b0;
        if (!cpu_stall) begin
            if ((word_addr >> ADDR_W) != '0) begin
                fetch_fault = 1'b1;
            end
`ifdef IMEM_ALIGN_CHECK_EN
            else if ((pc & PC_W'(BPW - 1)) != '0) begin
                fetch_fault = 1'b1;
            end
`endif
            else begin
                instruction = mem[word_addr[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_ldr.sv
module tb_instr_mem_ldr;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] instruction;
    logic        fetch_fault;
    logic        cpu_stall;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [4:0]  load_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_mem_ldr #(.DATA_W(16), .ADDR_W(4), .PC_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .fetch_fault (fetch_fault),
        .cpu_stall   (cpu_stall),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!ld_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            check("ready_timeout", {31'd0, ld_ready}, 32'd1);
        end else begin
            check("stall_in_load", {31'd0, cpu_stall}, 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = 8'h55;
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic start_load(input logic offer_byte);
        ld_start = 1'b1;
        ld_valid = offer_byte;
        ld_byte  = 8'hEE;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [15:0] a,
                         input logic [15:0] exp_instr, input logic exp_fault);
        pc = a;
        #1;
        check({tag, "_instr"}, {16'd0, instruction}, {16'd0, exp_instr});
        check({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, exp_fault});
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_count", {27'd0, load_count}, 32'd0);
        fetch("rst_pc0", 16'h0000, 16'h0000, 1'b0);

        // Plain 4-byte load; the byte offered alongside ld_start must be dropped.
        start_load(1'b1);
        check("load_stall", {31'd0, cpu_stall}, 32'd1);
        check("load_ready", {31'd0, ld_ready}, 32'd1);
        fetch("load_masked", 16'h0000, 16'h0000, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hB2, 1'b1);
        idle(1);
        check("s1_stall", {31'd0, cpu_stall}, 32'd0);
        check("s1_count", {27'd0, load_count}, 32'd2);
        fetch("s1_pc0", 16'h0000, 16'h8180, 1'b0);
        fetch("s1_pc2", 16'h0002, 16'h2CB2, 1'b0);
`ifdef IMEM_ALIGN_CHECK_EN
        fetch("s1_pc3", 16'h0003, 16'h0000, 1'b1);
`else
        fetch("s1_pc3", 16'h0003, 16'h2CB2, 1'b0);
`endif
        fetch("s1_pc4", 16'h0004, 16'h0000, 1'b0);

        // ld_valid toggling: junk byte 0x55 on the bus while valid is low.
        start_load(1'b0);
        send_byte(8'hDE, 1'b0); idle(1);
        send_byte(8'hAD, 1'b0); idle(1);
        send_byte(8'hBE, 1'b0); idle(1);
        send_byte(8'hEF, 1'b1); idle(1);
        check("s2_count", {27'd0, load_count}, 32'd2);
        fetch("s2_pc0", 16'h0000, 16'hDEAD, 1'b0);
        fetch("s2_pc2", 16'h0002, 16'hBEEF, 1'b0);
        fetch("s2_pc4", 16'h0004, 16'h0000, 1'b0);

        // 32 bytes, no ld_last: byte k = 3k+1, exit after word 15.
        start_load(1'b0);
        for (int k = 0; k < 32; k++) send_byte(8'(3 * k + 1), 1'b0);
        check("s3_stall", {31'd0, cpu_stall}, 32'd0);
        check("s3_count", {27'd0, load_count}, 32'd16);
        ld_valid = 1'b1;
        ld_byte  = 8'h99;
        #1 check("s3_ready33", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        check("s3_count33", {27'd0, load_count}, 32'd16);
        check("s3_stall33", {31'd0, cpu_stall}, 32'd0);
        idle(1);
        fetch("s3_pc30", 16'd30, 16'h5B5E, 1'b0);
        fetch("s3_pc2", 16'd2, 16'h070A, 1'b0);
        fetch("s3_pc32", 16'd32, 16'h0000, 1'b1);
        fetch("s3_pcmax", 16'hFFFE, 16'h0000, 1'b1);

        // Odd byte count: last word zero-filled; words from 2 up keep old data.
        start_load(1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        idle(1);
        check("s4_count", {27'd0, load_count}, 32'd2);
        fetch("s4_pc0", 16'd0, 16'hAABB, 1'b0);
        fetch("s4_pc2", 16'd2, 16'hCC00, 1'b0);
        fetch("s4_pc4", 16'd4, 16'h0D10, 1'b0);
        fetch("s4_pc30", 16'd30, 16'h5B5E, 1'b0);

        // Reset after the third byte.
        start_load(1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("s5_stall", {31'd0, cpu_stall}, 32'd0);
        check("s5_count", {27'd0, load_count}, 32'd0);
        check("s5_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fetch("s5_pc0", 16'd0, 16'h1122, 1'b0);
        fetch("s5_pc2", 16'd2, 16'hCC00, 1'b0);
`ifdef IMEM_ALIGN_CHECK_EN
        fetch("s5_pc1", 16'd1, 16'h0000, 1'b1);
`else
        fetch("s5_pc1", 16'd1, 16'h1122, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
